// File: rtl/data_mem_responder_pkg.sv
// rtl/data_mem_responder_pkg.sv - shared encodings for the data-memory responder
//
// Purpose: FSM state encoding, MMIO register offsets and counter width shared
//          by data_mem_responder and its RAM sub-module.
// Ports:   none (package).
package data_mem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam logic [1:0] MMIO_SW   = 2'd0;
    localparam logic [1:0] MMIO_LED  = 2'd1;
    localparam logic [1:0] MMIO_SCR  = 2'd2;
    localparam logic [1:0] MMIO_STAT = 2'd3;

    // Latencies are 1..15, so the remaining-cycles counter needs 4 bits.
    localparam int CNT_W = 4;

endpackage

// File: rtl/sync_ram_8bit.sv
// rtl/sync_ram_8bit.sv - single-port storage array with registered read
//
// Purpose: 2^ADDR_W x DATA_W array. Writes on we; read data is registered into
//          q on rd_en and held until the next read. The array itself is never
//          cleared by reset; only the read register is.
// Ports:
//   clock   in   1       clock
//   resetn  in   1       asynchronous active-low reset of q
//   we      in   1       write enable
//   rd_en   in   1       load q from the addressed word
//   addr    in   ADDR_W  word address
//   wdata   in   DATA_W  write data
//   q       out  DATA_W  registered read data
module sync_ram_8bit #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              we,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            q <= '0;
        end else if (rd_en) begin
            q <= mem[addr];
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - data-memory bus responder with programmable latency and MMIO
//
// Purpose: accepts MemRead/MemWrite requests, completes each one after a fixed
//          per-type latency with a one-cycle mem_ready pulse, and serves a
//          4-register MMIO window (switches, LEDs, scratch, status) at MMIO_BASE.
// Ports:
//   clock      in   1       clock
//   resetn     in   1       asynchronous active-low reset
//   mem_read   in   1       read strobe (level)
//   mem_write  in   1       write strobe (level)
//   address    in   ADDR_W  byte address
//   wdata      in   DATA_W  write data
//   rdata      out  DATA_W  registered read data, held until the next read completes
//   mem_ready  out  1       one-cycle completion pulse
//   sw_in      in   5       board switches
//   led_out    out  DATA_W  LED register
//   proto_err  out  1       sticky protocol-error flag
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int                ADDR_W     = 8,
    parameter int                DATA_W     = 8,
    parameter int                RD_LATENCY = 2,
    parameter int                WR_LATENCY = 1,
    parameter logic [ADDR_W-1:0] MMIO_BASE  = 8'hFC
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_ready,
    input  logic [4:0]        sw_in,
    output logic [DATA_W-1:0] led_out,
    output logic              proto_err
);

    localparam logic [CNT_W-1:0] RD_M1 = CNT_W'(RD_LATENCY - 1);
    localparam logic [CNT_W-1:0] WR_M1 = CNT_W'(WR_LATENCY - 1);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              cap_wr;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_wdata;

    logic              accept;
    logic [CNT_W-1:0]  lat_m1;
    logic              op_wr;
    logic [ADDR_W-1:0] op_addr;
    logic [DATA_W-1:0] op_wdata;
    logic [ADDR_W-1:0] op_off;
    logic              op_mmio;
    logic              commit;

    logic [4:0]        sw_q1, sw_q2;
    logic [DATA_W-1:0] scr_q;
    logic [DATA_W-1:0] rd_mmio_q;
    logic              rd_sel_mmio;
    logic [DATA_W-1:0] mmio_val;
    logic [DATA_W-1:0] ram_q;
    logic              err_set, err_clr;

    assign accept = (state == ST_IDLE) && (mem_read || mem_write);
    // Write wins when both strobes are up.
    assign lat_m1 = mem_write ? WR_M1 : RD_M1;

    // The operation being worked on: live inputs while in IDLE (a latency-1
    // access completes on its acceptance edge), captured copies otherwise.
    assign op_wr    = (state == ST_IDLE) ? mem_write : cap_wr;
    assign op_addr  = (state == ST_IDLE) ? address   : cap_addr;
    assign op_wdata = (state == ST_IDLE) ? wdata     : cap_wdata;
    assign op_off   = op_addr - MMIO_BASE;
    assign op_mmio  = (op_off < ADDR_W'(4));

    // The edge entering DONE is the commit edge, so results are visible
    // in the same cycle mem_ready is high.
    assign commit = (state_nxt == ST_DONE);

    // State register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. The counter holds the remaining BUSY cycles; DONE is
    // entered on the edge where it would reach zero.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = (lat_m1 == '0) ? ST_DONE : ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cnt == CNT_W'(1)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        mem_ready = (state == ST_DONE);
    end

    // Counter and request capture
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt       <= '0;
            cap_wr    <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
        end else if (accept) begin
            cnt       <= lat_m1;
            cap_wr    <= mem_write;
            cap_addr  <= address;
            cap_wdata <= wdata;
        end else if (state == ST_BUSY) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    sync_ram_8bit #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clock  (clock),
        .resetn (resetn),
        .we     (commit && op_wr && !op_mmio),
        .rd_en  (commit && !op_wr && !op_mmio),
        .addr   (op_addr),
        .wdata  (op_wdata),
        .q      (ram_q)
    );

    always_comb begin
        mmio_val = '0;
        unique case (op_off[1:0])
            MMIO_SW:   mmio_val = {{(DATA_W-5){1'b0}}, sw_q2};
            MMIO_LED:  mmio_val = led_out;
            MMIO_SCR:  mmio_val = scr_q;
            MMIO_STAT: mmio_val = {{(DATA_W-1){1'b0}}, proto_err};
            default:   mmio_val = '0;
        endcase
    end

    // Mismatched strobe type during an in-flight transaction, or both strobes
    // at acceptance, is a protocol error.
    assign err_set = (accept && mem_read && mem_write)
                   || ((state != ST_IDLE) && (cap_wr ? mem_read : mem_write));
    assign err_clr = commit && op_wr && op_mmio && (op_off[1:0] == MMIO_STAT) && op_wdata[0];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sw_q1       <= '0;
            sw_q2       <= '0;
            led_out     <= '0;
            scr_q       <= '0;
            proto_err   <= 1'b0;
            rd_mmio_q   <= '0;
            rd_sel_mmio <= 1'b0;
        end else begin
            sw_q1 <= sw_in;
            sw_q2 <= sw_q1;

            if (commit && op_wr && op_mmio) begin
                if (op_off[1:0] == MMIO_LED) begin
                    led_out <= op_wdata;
                end
                if (op_off[1:0] == MMIO_SCR) begin
                    scr_q <= op_wdata;
                end
            end

            if (commit && !op_wr) begin
                rd_sel_mmio <= op_mmio;
                if (op_mmio) begin
                    rd_mmio_q <= mmio_val;
                end
            end

            if (err_set) begin
                proto_err <= 1'b1;
            end else if (err_clr) begin
                proto_err <= 1'b0;
            end
        end
    end

    // Both sources are registers; the select only changes on a read commit,
    // so rdata holds until the next read completes.
    assign rdata = rd_sel_mmio ? rd_mmio_q : ram_q;

endmodule
